// File: rtl/m_level.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : m_level                                                        |
// | Brief   : Pipeline memory stage. Latches E-stage results, runs byte/half/ |
// |           word loads and stores over a req/ready port, stalls the pipe   |
// |           while an access is outstanding, and publishes M-stage          |
// |           forwarding info. Optional macro ALIGN_EXC_EN adds misaligned-  |
// |           address exceptions (M_AdEL / M_AdES).                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module m_level #(
    parameter int ADDR_BITS = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Reg_Rst,
    input  logic                 We,
    input  logic [31:0]          IR_in,
    input  logic [31:0]          PC_in,
    input  logic [31:0]          Y_in,
    input  logic [31:0]          V2_in,
    input  logic [4:0]           W_RFA3_in,
    input  logic [31:0]          W_RFWD_in,
    input  logic                 W_RFWr_in,
    input  logic                 W_Forward_Ready_in,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [3:0]           mem_be,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready,
    output logic [31:0]          IR_out,
    output logic [31:0]          PC_out,
    output logic [31:0]          Y_out,
    output logic [31:0]          DR_out,
    output logic                 M_Stall,
    output logic [4:0]           M_RFA3_out,
    output logic [31:0]          M_RFWD_out,
    output logic                 M_RFWr_out,
    output logic                 M_Forward_Ready_out
`ifdef ALIGN_EXC_EN
    ,
    output logic                 M_AdEL,
    output logic                 M_AdES
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_REGIMM  = 6'h01;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_LB      = 6'h20;
    localparam logic [5:0] c_OP_LH      = 6'h21;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_LBU     = 6'h24;
    localparam logic [5:0] c_OP_LHU     = 6'h25;
    localparam logic [5:0] c_OP_SB      = 6'h28;
    localparam logic [5:0] c_OP_SH      = 6'h29;
    localparam logic [5:0] c_OP_SW      = 6'h2B;
    localparam logic [5:0] c_FN_JALR    = 6'h09;

    state_t      r_state;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic [31:0] r_y;
    logic [31:0] r_v2;
    logic [31:0] r_dr;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [1:0]  w_a;
    logic        w_is_lb, w_is_lbu, w_is_lh, w_is_lhu, w_is_lw;
    logic        w_is_sb, w_is_sh, w_is_sw;
    logic        w_is_load, w_is_store, w_is_mem;
    logic        w_is_byte, w_is_half, w_is_word;
    logic        w_misal;
    logic        w_access;
    logic        w_wr_rt, w_wr_rd, w_wr_31, w_is_link;
    logic        w_rfwr;
    logic [31:0] w_fwd_rt;
    logic [31:0] w_st_src;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic        w_unused_ok;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_a     = r_y[1:0];

    assign w_is_lb  = (w_op == c_OP_LB);
    assign w_is_lbu = (w_op == c_OP_LBU);
    assign w_is_lh  = (w_op == c_OP_LH);
    assign w_is_lhu = (w_op == c_OP_LHU);
    assign w_is_lw  = (w_op == c_OP_LW);
    assign w_is_sb  = (w_op == c_OP_SB);
    assign w_is_sh  = (w_op == c_OP_SH);
    assign w_is_sw  = (w_op == c_OP_SW);

    assign w_is_load  = w_is_lb | w_is_lbu | w_is_lh | w_is_lhu | w_is_lw;
    assign w_is_store = w_is_sb | w_is_sh | w_is_sw;
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_is_byte  = w_is_lb | w_is_lbu | w_is_sb;
    assign w_is_half  = w_is_lh | w_is_lhu | w_is_sh;
    assign w_is_word  = w_is_lw | w_is_sw;

`ifdef ALIGN_EXC_EN
    assign w_misal = (w_is_half & w_a[0]) | (w_is_word & (w_a != 2'b00));
`else
    // Without exceptions the low bits are simply dropped: lanes below only
    // look at a[1] for halves and ignore a entirely for words.
    assign w_misal = 1'b0;
`endif

    assign w_access = w_is_mem & ~w_misal;

    assign mem_req = ((r_state == S_IDLE) & w_access) | (r_state == S_BUSY);
    assign M_Stall = ((r_state == S_IDLE) & w_is_mem) | (r_state == S_BUSY);

    // Destination-register decode mirrors the control unit's RFA3/RFWr select.
    always_comb begin
        w_wr_rt = 1'b0;
        w_wr_rd = 1'b0;
        w_wr_31 = 1'b0;
        case (w_op)
            c_OP_SPECIAL: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    c_FN_JALR, 6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: w_wr_rd = 1'b1;
                    default:      w_wr_rd = 1'b0;
                endcase
            end
            c_OP_REGIMM: w_wr_31 = (w_rt == 5'h10) | (w_rt == 5'h11);
            c_OP_JAL:    w_wr_31 = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
                         w_wr_rt = 1'b1;
            default:     w_wr_rt = w_is_load;
        endcase
    end

    assign w_is_link = w_wr_31 | (w_wr_rd & (w_funct == c_FN_JALR));
    assign w_rfwr    = (w_wr_rt | w_wr_rd | w_wr_31) & ~w_misal;

    assign M_RFA3_out          = w_wr_rd ? w_rd : (w_wr_rt ? w_rt : (w_wr_31 ? 5'd31 : 5'd0));
    assign M_RFWD_out          = w_is_link ? (r_pc + 32'd8) : r_y;
    assign M_RFWr_out          = w_rfwr;
    assign M_Forward_Ready_out = w_rfwr & ~w_is_load;

    assign w_fwd_rt = (w_rt == 5'd0) ? 32'd0 :
                      ((w_rt == W_RFA3_in) & W_RFWr_in & W_Forward_Ready_in) ? W_RFWD_in :
                      r_v2;

    // In the first cycle the live forward is used; afterwards the latched copy,
    // since the W stage will have moved on by then.
    assign w_st_src = (r_state == S_IDLE) ? w_fwd_rt : r_v2;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        if (w_is_byte) begin
            w_be = 4'b0001 << w_a;
        end else if (w_is_half) begin
            w_be = 4'b0011 << {w_a[1], 1'b0};
        end else if (w_is_word) begin
            w_be = 4'hF;
        end
        if (w_is_sb) begin
            w_wdata = {4{w_st_src[7:0]}};
        end else if (w_is_sh) begin
            w_wdata = {2{w_st_src[15:0]}};
        end else if (w_is_sw) begin
            w_wdata = w_st_src;
        end
    end

    assign mem_we    = mem_req & w_is_store;
    assign mem_be    = mem_req ? w_be : 4'b0000;
    assign mem_wdata = mem_we ? w_wdata : 32'd0;
    assign mem_addr  = mem_req ? {r_y[ADDR_BITS-1:2], 2'b00} : '0;

    always_comb begin
        w_byte     = 8'h00;
        w_load_val = 32'd0;
        case (w_a)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = w_a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (w_is_lb) begin
            w_load_val = {{24{w_byte[7]}}, w_byte};
        end else if (w_is_lbu) begin
            w_load_val = {24'd0, w_byte};
        end else if (w_is_lh) begin
            w_load_val = {{16{w_half[15]}}, w_half};
        end else if (w_is_lhu) begin
            w_load_val = {16'd0, w_half};
        end else if (w_is_lw) begin
            w_load_val = mem_rdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Reg_Rst) begin
            r_ir <= 32'd0;
            r_pc <= 32'd0;
            r_y  <= 32'd0;
            r_v2 <= 32'd0;
        end else if (We) begin
            r_ir <= IR_in;
            r_pc <= PC_in;
            r_y  <= Y_in;
            r_v2 <= V2_in;
        end else if ((r_state == S_IDLE) && w_is_store) begin
            r_v2 <= w_fwd_rt;
        end
    end

`ifdef ALIGN_EXC_EN
    logic r_adel;
    logic r_ades;
`endif

    always_ff @(posedge Clk) begin
        if (Rst || Reg_Rst) begin
            r_state <= S_IDLE;
            r_dr    <= 32'd0;
`ifdef ALIGN_EXC_EN
            r_adel  <= 1'b0;
            r_ades  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mem) begin
                        if (w_misal) begin
                            r_state <= S_DONE;
`ifdef ALIGN_EXC_EN
                            r_adel  <= w_is_load;
                            r_ades  <= w_is_store;
`endif
                        end else if (mem_ready) begin
                            r_state <= S_DONE;
                            r_dr    <= w_load_val;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        r_state <= S_DONE;
                        r_dr    <= w_load_val;
                    end
                end
                S_DONE: begin
                    // Hold the result until the hazard unit lets the pipe advance.
                    if (We) begin
                        r_state <= S_IDLE;
                        r_dr    <= 32'd0;
`ifdef ALIGN_EXC_EN
                        r_adel  <= 1'b0;
                        r_ades  <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_dr    <= 32'd0;
                end
            endcase
        end
    end

`ifdef ALIGN_EXC_EN
    assign M_AdEL = r_adel;
    assign M_AdES = r_ades;
`endif

    assign IR_out = r_ir;
    assign PC_out = r_pc;
    assign Y_out  = r_y;
    assign DR_out = r_dr;

    assign w_unused_ok = ^{r_ir[25:21], r_ir[10:6], r_y};

endmodule
`default_nettype wire

// File: tb/tb_m_level.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_m_level                                                     |
// | Brief   : Directed self-checking bench for the memory stage m_level.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_m_level;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Reg_Rst = 1'b0;
    logic        We = 1'b0;
    logic [31:0] IR_in = 32'd0;
    logic [31:0] PC_in = 32'd0;
    logic [31:0] Y_in = 32'd0;
    logic [31:0] V2_in = 32'd0;
    logic [4:0]  W_RFA3_in = 5'd0;
    logic [31:0] W_RFWD_in = 32'd0;
    logic        W_RFWr_in = 1'b0;
    logic        W_Forward_Ready_in = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ready = 1'b0;

    logic        mem_req, mem_we, M_Stall, M_RFWr_out, M_Forward_Ready_out;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, IR_out, PC_out, Y_out, DR_out, M_RFWD_out;
    logic [4:0]  M_RFA3_out;
`ifdef ALIGN_EXC_EN
    logic        M_AdEL, M_AdES;
`endif

    int vectors = 0;
    int miscompares = 0;
    int n;

    localparam logic [31:0] c_LW8   = {6'h23, 5'd0, 5'd8,  16'h0010};
    localparam logic [31:0] c_LB9   = {6'h20, 5'd0, 5'd9,  16'h0013};
    localparam logic [31:0] c_LBU9  = {6'h24, 5'd0, 5'd9,  16'h0013};
    localparam logic [31:0] c_SH10  = {6'h29, 5'd0, 5'd10, 16'h0022};
    localparam logic [31:0] c_SB11  = {6'h28, 5'd0, 5'd11, 16'h0001};
    localparam logic [31:0] c_SW0   = {6'h2B, 5'd0, 5'd0,  16'h0008};
    localparam logic [31:0] c_JAL   = {6'h03, 26'h0000C02};
    localparam logic [31:0] c_ADDU  = {6'h00, 5'd1, 5'd2, 5'd12, 5'd0, 6'h21};
    localparam logic [31:0] c_LH13  = {6'h21, 5'd0, 5'd13, 16'h0007};

    m_level #(.ADDR_BITS(32)) dut (
        .Clk(Clk), .Rst(Rst), .Reg_Rst(Reg_Rst), .We(We),
        .IR_in(IR_in), .PC_in(PC_in), .Y_in(Y_in), .V2_in(V2_in),
        .W_RFA3_in(W_RFA3_in), .W_RFWD_in(W_RFWD_in), .W_RFWr_in(W_RFWr_in),
        .W_Forward_Ready_in(W_Forward_Ready_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .IR_out(IR_out), .PC_out(PC_out), .Y_out(Y_out), .DR_out(DR_out),
        .M_Stall(M_Stall), .M_RFA3_out(M_RFA3_out), .M_RFWD_out(M_RFWD_out),
        .M_RFWr_out(M_RFWr_out), .M_Forward_Ready_out(M_Forward_Ready_out)
`ifdef ALIGN_EXC_EN
        , .M_AdEL(M_AdEL), .M_AdES(M_AdES)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] y, input logic [31:0] v2);
        IR_in = ir;
        PC_in = pc;
        Y_in  = y;
        V2_in = v2;
        We    = 1'b1;
        tick();
        We    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_stall", 32'(M_Stall), 32'd0);
        chk("rst_ir",    IR_out,       32'd0);
        chk("rst_dr",    DR_out,       32'd0);
        chk("rst_be",    32'(mem_be),  32'd0);
        Rst = 1'b0;
        tick();

        // lw, ready in the first request cycle
        issue(c_LW8, 32'h1000, 32'h10, 32'd0);
        chk("lw_stall1", 32'(M_Stall), 32'd1);
        chk("lw_req",    32'(mem_req), 32'd1);
        chk("lw_be",     32'(mem_be),  32'hF);
        chk("lw_addr",   mem_addr,     32'h10);
        chk("lw_we",     32'(mem_we),  32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        chk("lw_stall_done", 32'(M_Stall), 32'd0);
        chk("lw_req_done",   32'(mem_req), 32'd0);
        chk("lw_dr",         DR_out,       32'h12345678);
        chk("lw_a3",         32'(M_RFA3_out), 32'd8);
        chk("lw_fwdrdy",     32'(M_Forward_Ready_out), 32'd0);
        // mem_ready in DONE must be ignored and DONE must hold without We
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        chk("done_hold_dr",  DR_out,       32'h12345678);
        chk("done_hold_req", 32'(mem_req), 32'd0);

        // lb with three wait cycles
        issue(c_LB9, 32'h1004, 32'h13, 32'd0);
        n = 0;
        while (M_Stall === 1'b1 && n < 20) begin
            if (n == 0) chk("lb_addr", mem_addr, 32'h10);
            if (n == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h80FFFFFF;
            end
            n++;
            tick();
            mem_ready = 1'b0;
        end
        chk("lb_stall_cycles", 32'(n), 32'd4);
        chk("lb_dr",           DR_out, 32'hFFFFFF80);

        // lbu, same address and data
        issue(c_LBU9, 32'h1008, 32'h13, 32'd0);
        chk("lbu_be", 32'(mem_be), 32'b1000);
        mem_ready = 1'b1;
        mem_rdata = 32'h80FFFFFF;
        tick();
        mem_ready = 1'b0;
        chk("lbu_dr", DR_out, 32'h00000080);

        // sh with rt forwarded from W
        W_RFA3_in = 5'd10;
        W_RFWD_in = 32'hAAAA5555;
        W_RFWr_in = 1'b1;
        W_Forward_Ready_in = 1'b1;
        issue(c_SH10, 32'h100C, 32'h22, 32'h11112222);
        chk("sh_be",    32'(mem_be), 32'b1100);
        chk("sh_wdata", mem_wdata,   32'h55555555);
        chk("sh_we",    32'(mem_we), 32'd1);
        chk("sh_addr",  mem_addr,    32'h20);
        tick();
        W_RFWr_in = 1'b0;
        W_RFWD_in = 32'h0;
        #1;
        chk("sh_busy_wdata", mem_wdata, 32'h55555555);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("sh_done_req", 32'(mem_req), 32'd0);
        chk("sh_dr",       DR_out,       32'd0);
        chk("sh_rfwr",     32'(M_RFWr_out), 32'd0);

        // sb without forwarding, byte lane 1
        issue(c_SB11, 32'h1010, 32'h01, 32'h000000AB);
        chk("sb_be",    32'(mem_be), 32'b0010);
        chk("sb_wdata", mem_wdata,   32'hABABABAB);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // sw of $0 stores zero whatever V2 carries
        issue(c_SW0, 32'h1014, 32'h08, 32'hDEADBEEF);
        chk("sw0_wdata", mem_wdata,   32'd0);
        chk("sw0_be",    32'(mem_be), 32'hF);
        // bubble insert while the store is pending
        Reg_Rst = 1'b1;
        tick();
        Reg_Rst = 1'b0;
        chk("regrst_req", 32'(mem_req), 32'd0);
        chk("regrst_ir",  IR_out,       32'd0);
        chk("regrst_stall", 32'(M_Stall), 32'd0);

        // Rst in BUSY, then a late mem_ready
        issue(c_LW8, 32'h1018, 32'h10, 32'd0);
        tick();
        chk("rst_busy_req", 32'(mem_req), 32'd1);
        Rst = 1'b1;
        tick();
        chk("rst_mid_req",   32'(mem_req), 32'd0);
        chk("rst_mid_stall", 32'(M_Stall), 32'd0);
        chk("rst_mid_ir",    IR_out,       32'd0);
        Rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEBABE;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("late_ready_dr",  DR_out,       32'd0);
        chk("late_ready_req", 32'(mem_req), 32'd0);

        // jal in M
        issue(c_JAL, 32'h3000, 32'h1234, 32'd0);
        chk("jal_a3",     32'(M_RFA3_out), 32'd31);
        chk("jal_wd",     M_RFWD_out,      32'h3008);
        chk("jal_fwdrdy", 32'(M_Forward_Ready_out), 32'd1);
        chk("jal_stall",  32'(M_Stall),    32'd0);
        chk("jal_rfwr",   32'(M_RFWr_out), 32'd1);

        // addu writes rd with Y
        issue(c_ADDU, 32'h3004, 32'h00000777, 32'd0);
        chk("addu_a3", 32'(M_RFA3_out), 32'd12);
        chk("addu_wd", M_RFWD_out,      32'h00000777);

`ifdef ALIGN_EXC_EN
        issue(c_LW8, 32'h3008, 32'h06, 32'd0);
        chk("misal_req",   32'(mem_req), 32'd0);
        chk("misal_rfwr",  32'(M_RFWr_out), 32'd0);
        tick();
        chk("misal_adel",  32'(M_AdEL),  32'd1);
        chk("misal_ades",  32'(M_AdES),  32'd0);
        chk("misal_stall", 32'(M_Stall), 32'd0);
`else
        issue(c_LW8, 32'h3008, 32'h06, 32'd0);
        chk("misal_addr", mem_addr,     32'h4);
        chk("misal_be",   32'(mem_be),  32'hF);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        chk("misal_dr",   DR_out,       32'hCAFEF00D);

        issue(c_LH13, 32'h300C, 32'h07, 32'd0);
        chk("lh_be",   32'(mem_be), 32'b1100);
        chk("lh_addr", mem_addr,    32'h4);
        mem_ready = 1'b1;
        mem_rdata = 32'h80011234;
        tick();
        mem_ready = 1'b0;
        chk("lh_dr",   DR_out,      32'hFFFF8001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
